// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the Morty MEM stage: access sizes, exception codes,
// FSM states and the alignment check.
package mem_access_stage_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [3:0] EXC_NONE   = 4'd0;
    localparam logic [3:0] EXC_LD_MIS = 4'd4;
    localparam logic [3:0] EXC_LD_FLT = 4'd5;
    localparam logic [3:0] EXC_ST_MIS = 4'd6;
    localparam logic [3:0] EXC_ST_FLT = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reserved size 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if (size == SZ_H)
            mis = lo[0];
        else if (size != SZ_B)
            mis = (lo != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: store byte enables and lane replication, plus load
// lane extraction with sign/zero extension. Purely combinational.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: byte enables and data replicated across every lane it may hit.
    always_comb begin
        case (i_size)
            SZ_B: begin
                o_sel   = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                o_sel   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_sel   = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Load side: pick the addressed lane and extend to 32 bits.
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            SZ_B:    o_rdata = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SZ_H:    o_rdata = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the Morty pipeline: issues one Wishbone-style data access per
// load/store, stalls the front of the pipe while the access is outstanding,
// and reports misaligned/fault exceptions.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic        kill_i,
    input  logic        hold_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic [3:0]  exc_o,
    output logic [31:0] dbus_adr_o,
    output logic [31:0] dbus_dat_o,
    output logic [3:0]  dbus_sel_o,
    output logic        dbus_we_o,
    output logic        dbus_cyc_o,
    output logic        dbus_stb_o,
    input  logic [31:0] dbus_dat_i,
    input  logic        dbus_ack_i,
    input  logic        dbus_err_i
);

    localparam int             CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT);

    state_t        r_state;
    logic [31:0]   r_adr;
    logic [31:0]   r_dat;
    logic [31:0]   r_rdata;
    logic [3:0]    r_sel;
    logic [3:0]    r_exc;
    logic          r_we;
    logic          r_cyc;
    logic          r_uns;
    logic [1:0]    r_size;
    logic [1:0]    r_lo;
    logic [CW-1:0] r_cnt;

    logic          w_req;
    logic          w_mis;
    logic          w_idle;
    logic [1:0]    w_al_size;
    logic [1:0]    w_al_lo;
    logic [3:0]    w_al_sel;
    logic [31:0]   w_al_wdata;
    logic [31:0]   w_al_rdata;

    assign w_req  = (mem_rd_i | mem_wr_i) & ~kill_i;
    assign w_mis  = is_misaligned(size_i, addr_i[1:0]);
    assign w_idle = (r_state == ST_IDLE);

    // In IDLE the aligner shapes the incoming store; once on the bus it
    // extracts the load using the attributes latched at issue.
    assign w_al_size = w_idle ? size_i      : r_size;
    assign w_al_lo   = w_idle ? addr_i[1:0] : r_lo;

    mem_lane_align u_align (
        .i_size     (w_al_size),
        .i_addr_lo  (w_al_lo),
        .i_unsigned (r_uns),
        .i_wdata    (wdata_i),
        .i_rdata    (dbus_dat_i),
        .o_sel      (w_al_sel),
        .o_wdata    (w_al_wdata),
        .o_rdata    (w_al_rdata)
    );

    // Access FSM: issue, wait for ack/err/timeout, then present the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_adr   <= '0;
            r_dat   <= '0;
            r_rdata <= '0;
            r_sel   <= '0;
            r_exc   <= EXC_NONE;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= SZ_B;
            r_lo    <= 2'b00;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req && !w_mis) begin
                        r_adr   <= {addr_i[31:2], 2'b00};
                        r_dat   <= w_al_wdata;
                        r_sel   <= w_al_sel;
                        r_we    <= mem_wr_i;
                        r_cyc   <= 1'b1;
                        r_uns   <= unsigned_i;
                        r_size  <= size_i;
                        r_lo    <= addr_i[1:0];
                        r_cnt   <= '0;
                        r_exc   <= EXC_NONE;
                        r_state <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (dbus_err_i) begin
                        r_exc   <= r_we ? EXC_ST_FLT : EXC_LD_FLT;
                        r_cyc   <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (dbus_ack_i) begin
                        if (!r_we)
                            r_rdata <= w_al_rdata;
                        r_cyc   <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (r_cnt == TO_VAL) begin
                        r_exc   <= r_we ? EXC_ST_FLT : EXC_LD_FLT;
                        r_cyc   <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!hold_i) begin
                        r_exc   <= EXC_NONE;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Misaligned requests are reported in IDLE without touching the bus.
    assign exc_o   = w_idle ? ((w_req && w_mis) ? (mem_wr_i ? EXC_ST_MIS : EXC_LD_MIS) : EXC_NONE)
                            : r_exc;
    assign stall_o = (w_idle && w_req && !w_mis) || (r_state == ST_BUS);
    assign rdata_o = r_rdata;

    assign dbus_adr_o = r_adr;
    assign dbus_dat_o = r_dat;
    assign dbus_sel_o = r_sel;
    assign dbus_we_o  = r_we;
    assign dbus_cyc_o = r_cyc;
    assign dbus_stb_o = r_cyc;

endmodule
